mac_vector_unit: RTL and testbench

Parametrised successor to the single-pair MAC unit. It accepts a stream of (x, w) operand pairs over a valid/ready handshake and accumulates exactly VEC_LEN products per dot product. Each completed result is presented on a valid/ready output with an overflow flag, and overflow is handled by saturation or wrap-around. It sits between the operand fetch logic and the activation/writeback stage of the compute datapath.

---
 rtl/mac_pkg.sv | 9 +
 rtl/mac_sat_add.sv | 21 ++
 rtl/mac_vector_unit.sv | 96 +++++++++
 tb/tb_mac_vector_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: default widths and parameter sanity check shared by the MAC vector units.
package mac_pkg;
   localparam int DATA_W_DEF  = 8;
   localparam int ACC_W_DEF   = 24;
   localparam int VEC_LEN_DEF = 4;
   function automatic bit widths_ok(int data_w, int acc_w, int vec_len);
      return (data_w >= 1) && (acc_w >= 2 * data_w) && (vec_len >= 1);
   endfunction
endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: accumulator add with sticky carry flag and optional clamp to all-ones.
module mac_sat_add
   import mac_pkg::*;
#(
   parameter int ACC_W    = ACC_W_DEF,
   parameter bit SATURATE = 1'b1
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   input  logic             ovf_in,
   output logic [ACC_W-1:0] sum,
   output logic             ovf_out
);
   logic [ACC_W:0] wide;
   always_comb begin
      wide    = {1'b0, a} + {1'b0, b};
      ovf_out = ovf_in | wide[ACC_W];
      // once the vector has overflowed, the clamp keeps it pinned at all-ones
      sum     = (SATURATE && ovf_out) ? '1 : wide[ACC_W-1:0];
   end
endmodule

// File: rtl/mac_vector_unit.sv
// mac_vector_unit: streaming dot-product engine; product stage, accumulator stage and a
// single-entry output register behind valid/ready handshakes.
module mac_vector_unit
   import mac_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ACC_W    = ACC_W_DEF,
   parameter int VEC_LEN  = VEC_LEN_DEF,
   parameter bit SATURATE = 1'b1,
   parameter int CNT_W    = $clog2(VEC_LEN + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] w,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              overflow,
   output logic [CNT_W-1:0]  count
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

   if (!widths_ok(DATA_W, ACC_W, VEC_LEN)) begin : g_bad_params
      $error("mac_vector_unit: illegal DATA_W/ACC_W/VEC_LEN combination");
   end

   logic [2*DATA_W-1:0] p_prod_q, p_prod_d;
   logic                p_valid_q, p_valid_d, p_last_q, p_last_d;
   logic [CNT_W-1:0]    idx_q, idx_d, count_q, count_d;
   logic [ACC_W-1:0]    acc_q, acc_d, out_acc_q, out_acc_d, sum;
   logic                ovf_q, ovf_d, out_ovf_q, out_ovf_d, out_valid_q, out_valid_d;
   logic                sum_ovf, flush, stall, in_fire, a_fire, load;

   mac_sat_add #(.ACC_W(ACC_W), .SATURATE(SATURATE)) u_add (
      .a      (acc_q),
      .b      (ACC_W'(p_prod_q)),
      .ovf_in (ovf_q),
      .sum    (sum),
      .ovf_out(sum_ovf)
   );

   always_comb begin
      flush       = clear || !reset_n;
      // a finished last product can only wait in stage P while the output slot is occupied
      stall       = p_valid_q && p_last_q && out_valid_q && !out_ready;
      in_ready    = !stall && !clear && reset_n;
      in_fire     = in_valid && in_ready;
      a_fire      = p_valid_q && !stall;
      load        = a_fire && p_last_q;
      p_valid_d   = stall ? p_valid_q : in_fire;
      p_prod_d    = in_fire ? {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, w} : p_prod_q;
      p_last_d    = in_fire ? (idx_q == LAST) : p_last_q;
      idx_d       = in_fire ? ((idx_q == LAST) ? '0 : idx_q + 1'b1) : idx_q;
      acc_d       = a_fire ? (p_last_q ? '0 : sum) : acc_q;
      ovf_d       = a_fire ? (!p_last_q && sum_ovf) : ovf_q;
      count_d     = a_fire ? (p_last_q ? '0 : count_q + 1'b1) : count_q;
      out_valid_d = load || (out_valid_q && !out_ready);
      out_acc_d   = load ? sum : out_acc_q;
      out_ovf_d   = load ? sum_ovf : out_ovf_q;
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         p_prod_q    <= '0;
         p_valid_q   <= 1'b0;
         p_last_q    <= 1'b0;
         idx_q       <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_acc_q   <= '0;
         out_ovf_q   <= 1'b0;
      end else begin
         p_prod_q    <= p_prod_d;
         p_valid_q   <= p_valid_d;
         p_last_q    <= p_last_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_acc_q   <= out_acc_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign acc_out   = out_acc_q;
   assign overflow  = out_ovf_q;
   assign count     = count_q;
endmodule

// File: tb/tb_mac_vector_unit.sv
// tb_mac_vector_unit: directed and random streams into a saturating and a wrapping instance,
// checked against a sum-of-products reference.
module tb_mac_vector_unit;
   localparam int DW = 8;
   localparam int AW = 16;
   localparam int VL = 3;
   localparam int CW = $clog2(VL + 1);
   localparam longint unsigned LIM = 64'd1 << AW;

   logic          clk = 1'b0, reset_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [DW-1:0] x = '0, w = '0;
   logic          ir_s, ir_w, ov_s, ov_w, of_s, of_w;
   logic [AW-1:0] acc_s, acc_w;
   logic [CW-1:0] cnt_s, cnt_w;

   longint unsigned exp_q[$];
   longint unsigned part = 0;
   int n_part = 0, total = 0, fails = 0, cyc = 0, last_out = -100, gap = 0, fired_in = 0;
   logic [AW-1:0] hold;

   always #5 clk = ~clk;

   mac_vector_unit #(.DATA_W(DW), .ACC_W(AW), .VEC_LEN(VL), .SATURATE(1'b1)) dut_s (
      .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(ir_s),
      .x(x), .w(w), .out_valid(ov_s), .out_ready(out_ready), .acc_out(acc_s),
      .overflow(of_s), .count(cnt_s)
   );

   mac_vector_unit #(.DATA_W(DW), .ACC_W(AW), .VEC_LEN(VL), .SATURATE(1'b0)) dut_w (
      .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_ready(ir_w),
      .x(x), .w(w), .out_valid(ov_w), .out_ready(out_ready), .acc_out(acc_w),
      .overflow(of_w), .count(cnt_w)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // One clock cycle: drive at the falling edge, then observe handshakes before the next rise.
   task automatic cycle(input bit iv, input bit [7:0] xx, input bit [7:0] ww,
                        input bit ordy, input bit clr, input bit rn);
      longint unsigned e;
      @(negedge clk);
      in_valid = iv; x = xx; w = ww; out_ready = ordy; clear = clr; reset_n = rn;
      #1;
      cyc++;
      chk("in_ready_match", ir_w, ir_s);
      if (ov_s && out_ready) begin
         chk("result_pending", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("acc_sat", acc_s, (e >= LIM) ? LIM - 1 : e);
            chk("ovf_sat", of_s, e >= LIM);
            chk("acc_wrap", acc_w, e % LIM);
            chk("ovf_wrap", of_w, e >= LIM);
            chk("valid_wrap", ov_w, 1);
         end
         gap = cyc - last_out;
         last_out = cyc;
      end
      if (in_valid && ir_s) begin
         part += longint'(xx) * longint'(ww);
         n_part++;
         fired_in++;
         if (n_part == VL) begin
            exp_q.push_back(part);
            part = 0;
            n_part = 0;
         end
      end
      if (clr || !rn) begin
         exp_q.delete();
         part = 0;
         n_part = 0;
      end
   endtask

   initial begin
      repeat (3) cycle(0, 0, 0, 0, 0, 0);
      chk("rst_out_valid", ov_s, 0);
      chk("rst_acc_out", acc_s, 0);
      chk("rst_overflow", of_s, 0);
      chk("rst_count", cnt_s, 0);
      chk("rst_in_ready", ir_s, 0);
      cycle(0, 0, 0, 1, 0, 1);
      chk("in_ready_after_release", ir_s, 1);

      cycle(1, 2, 3, 1, 0, 1);
      cycle(1, 4, 5, 1, 0, 1);
      cycle(1, 6, 7, 1, 0, 1);
      cycle(0, 0, 0, 1, 0, 1);
      chk("latency_not_early", ov_s, 0);
      cycle(0, 0, 0, 1, 0, 1);
      chk("latency_valid", ov_s, 1);
      chk("basic_acc", acc_s, 68);
      chk("basic_ovf", of_s, 0);
      repeat (2) cycle(0, 0, 0, 1, 0, 1);

      repeat (VL) cycle(1, 1, 1, 1, 0, 1);
      repeat (VL) cycle(1, 3, 3, 1, 0, 1);
      repeat (4) cycle(0, 0, 0, 1, 0, 1);
      chk("b2b_result_gap", gap, VL);
      chk("b2b_drained", exp_q.size(), 0);

      repeat (VL) cycle(1, 255, 255, 1, 0, 1);
      cycle(0, 0, 0, 1, 0, 1);
      cycle(0, 0, 0, 1, 0, 1);
      chk("sat_acc", acc_s, 65535);
      chk("wrap_acc", acc_w, 64003);
      chk("sat_flag", of_s, 1);
      repeat (2) cycle(0, 0, 0, 1, 0, 1);

      fired_in = 0;
      hold = '0;
      for (int i = 0; i < 10; i++) begin
         cycle(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 0, 1);
         if (i == 5) hold = acc_s;
      end
      chk("bp_accepted", fired_in, 2 * VL);
      chk("bp_in_ready_low", ir_s, 0);
      chk("bp_out_valid", ov_s, 1);
      chk("bp_acc_stable", acc_s, hold);
      repeat (8) cycle(0, 0, 0, 1, 0, 1);
      chk("bp_drained", exp_q.size(), 0);

      cycle(1, 9, 9, 1, 0, 1);
      cycle(1, 9, 9, 1, 0, 1);
      cycle(1, 5, 5, 1, 1, 1);
      chk("count_before_clear", cnt_s, 1);
      chk("in_ready_during_clear", ir_s, 0);
      cycle(1, 1, 2, 1, 0, 1);
      chk("count_after_clear", cnt_s, 0);
      chk("valid_after_clear", ov_s, 0);
      repeat (VL - 1) cycle(1, 1, 2, 1, 0, 1);
      cycle(0, 0, 0, 1, 0, 1);
      cycle(0, 0, 0, 1, 0, 1);
      chk("clear_result", acc_s, 6);
      repeat (2) cycle(0, 0, 0, 1, 0, 1);

      repeat (VL) cycle(1, 200, 200, 0, 0, 1);
      repeat (2) cycle(0, 0, 0, 0, 0, 1);
      chk("valid_before_reset", ov_s, 1);
      chk("ovf_before_reset", of_s, 1);
      cycle(0, 0, 0, 0, 0, 0);
      chk("in_ready_in_reset", ir_s, 0);
      cycle(0, 0, 0, 0, 0, 1);
      chk("reset_out_valid", ov_s, 0);
      chk("reset_acc_out", acc_s, 0);
      chk("reset_overflow", of_s, 0);
      chk("reset_count", cnt_s, 0);
      chk("reset_in_ready", ir_s, 1);

      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0, 1);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle(0, 0, 0, 1, 0, 1);
      chk("random_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
